// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the fetch-stage next-PC unit: next-PC mode encodings
// and a small helper for PC-relative arithmetic.
package next_pc_unit_pkg;

    // Next-PC mode select. These are the 3-bit versions of the former 2-bit
    // encodings; the original values keep their positions, RET is new.
    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_JR     = 3'd3,
        NPC_RET    = 3'd4
    } npc_mode_e;

    localparam int NPC_MODE_W = 3;

    // Word offset to byte offset; the two top bits of the offset fall off.
    function automatic logic [31:0] word_to_byte32(input logic [31:0] words);
        return words << 2;
    endfunction

endpackage

// File: rtl/next_pc_unit_ras_stack.sv
// Circular return-address stack. The write pointer names the slot the next
// push lands in, so the top entry sits one slot behind it. When the stack is
// full that same slot holds the oldest entry, which makes an overflowing push
// overwrite the oldest address without extra logic.
module ras_stack
    import next_pc_unit_pkg::*;
#(
    parameter int W         = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [W-1:0]  entry [RAS_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] top_ptr;
    logic [CW-1:0] count;

    logic do_push;
    logic do_pop;
    logic do_replace;

    // Classify the request; a pop on an empty stack is dropped, and a
    // push+pop on an empty stack degenerates into a plain push.
    always_comb begin
        top_ptr    = wr_ptr - PTR_ONE;
        empty      = (count == '0);
        full       = (count == FULL_CNT);
        do_replace = push && pop && !empty;
        do_push    = push && !do_replace;
        do_pop     = pop && !push && !empty;
        top        = entry[top_ptr];
    end

    // Pointer and occupancy; count saturates at RAS_DEPTH on overflow pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (!full)
                count <= count + CNT_ONE;
        end else if (do_pop) begin
            wr_ptr <= top_ptr;
            count  <= count - CNT_ONE;
        end
    end

    // Entry storage; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (do_push)
            entry[wr_ptr] <= push_data;
        else if (do_replace)
            entry[top_ptr] <= push_data;
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch-stage program counter: holds the PC and picks the next one from the
// decoded mode (sequential, branch, jump, register jump, predicted return),
// with an exception redirect that wins over stall.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int          W         = 32,
    parameter int          JW        = 26,
    parameter logic [W-1:0] RESET_VEC = 32'h0000_3000,
    parameter logic [W-1:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Stall,
    input  logic                  Except,
    input  logic [NPC_MODE_W-1:0] NPCCtrl,
    input  logic                  Branch,
    input  logic [W-1:0]          NPC,
    input  logic [W-1:0]          Imm,
    input  logic [W-1:0]          JumpAddr,
    input  logic                  Link,
    output logic [W-1:0]          PC,
    output logic                  RasEmpty,
    output logic                  RasFull
);

    localparam logic [W-1:0] FOUR = W'(4);

    logic [W-1:0] next_pc;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] branch_target;
    logic [W-1:0] jump_target;
    logic [W-1:0] ras_top;
    logic [W-1:0] ret_addr;
    logic         advance;
    logic         ras_push;
    logic         ras_pop;

    // Candidate targets and the RAS request qualification. Exception and
    // stall both freeze the stack, so only an advancing cycle touches it.
    always_comb begin
        pc_plus4      = PC + FOUR;
        branch_target = NPC + (Imm << 2);
        jump_target   = {NPC[W-1:JW+2], JumpAddr[JW-1:0], 2'b00};
        ret_addr      = NPC + FOUR;
        advance       = !Except && !Stall;
        ras_push      = advance && Link;
        ras_pop       = advance && (NPCCtrl == NPC_RET);
    end

    // Next-PC mux; reserved mode codes fall through to sequential fetch.
    always_comb begin
        next_pc = pc_plus4;
        case (NPCCtrl)
            NPC_PLUS4:  next_pc = pc_plus4;
            NPC_BRANCH: next_pc = Branch ? branch_target : pc_plus4;
            NPC_JUMP:   next_pc = jump_target;
            NPC_JR:     next_pc = JumpAddr;
            NPC_RET:    next_pc = RasEmpty ? JumpAddr : ras_top;
            default:    next_pc = pc_plus4;
        endcase
    end

    // PC register: exception redirect, then stall hold, then normal advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            PC <= RESET_VEC;
        else if (Except)
            PC <= EXC_VEC;
        else if (!Stall)
            PC <= next_pc;
    end

    ras_stack #(
        .W         (W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ret_addr),
        .top       (ras_top),
        .empty     (RasEmpty),
        .full      (RasFull)
    );

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Registered program-counter generator for the MIPS fetch stage: holds the PC and computes next-PC each cycle from the control mode.
- Supports sequential, conditional branch, J-type jump, register jump, exception vector and predicted return.
- The predicted return is served by a parametrised circular return-address stack (RAS).
- Sits between decode/control (mode, branch outcome, immediates) and instruction memory (PC output).

Parameters:
- W, 32, PC/data width (W >= JW+4).
- JW, 26, J-type target field width.
- RESET_VEC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, PC loaded on exception.
- RAS_DEPTH, 4, RAS entries (power of two, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Stall  in  1  hold PC and RAS this cycle.
- Except  in  1  exception redirect; overrides Stall.
- NPCCtrl  in  3  next-PC mode, encodings from CtrlDef.v.
- Branch  in  1  branch condition resolved true.
- NPC  in  W  PC of delay-slot instruction (branch PC + 4).
- Imm  in  W  sign-extended branch offset in words.
- JumpAddr  in  W  J target in bits [JW-1:0] for JUMP; full register target for JR/RET fallback.
- Link  in  1  push return address (JAL/JALR) this cycle.
- PC  out  W  current fetch PC (registered).
- RasEmpty  out  1  RAS holds no valid entry.
- RasFull  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset (async assert, any time): PC=RESET_VEC; RAS count=0, top pointer=0; RasEmpty=1, RasFull=0. Entry contents are don't-care.
- Next-PC computation (combinational, W-bit, wrap modulo 2^W):
  - PLUS4 (0): PC+4.
  - BRANCH (1): Branch ? NPC+(Imm<<2) : PC+4. Bits shifted out of Imm are dropped.
  - JUMP (2): {NPC[W-1:JW+2], JumpAddr[JW-1:0], 2'b00}.
  - JR (3): JumpAddr.
  - RET (4): RAS top if not empty, else JumpAddr.
  - 5–7: PC+4.
- Update priority, evaluated on each rising edge:
  - Except=1: PC<=EXC_VEC; RAS unchanged; Link and RET ignored.
  - Else Stall=1: PC, RAS hold; all controls ignored.
  - Else: PC<=next-PC. Latency is one cycle: PC reflects a mode presented in cycle N from cycle N+1.
- RAS push (Link=1, not stalled, no Except): pushed value = NPC+4, the return address after the delay slot.
  - Not full: count+1, top advances.
  - Full: overwrite the oldest entry (top advances circularly); count stays RAS_DEPTH.
- RAS pop (mode RET, not stalled, no Except):
  - Not empty: count-1, top retreats.
  - Empty: no change; fallback to JumpAddr.
- Simultaneous push and pop (RET with Link):
  - Non-empty: top entry replaced by NPC+4, count unchanged. Next-PC uses the old top.
  - Empty: behaves as push.
- Pointer arithmetic is modulo RAS_DEPTH; count saturates at 0 and RAS_DEPTH.
- RasEmpty = (count==0); RasFull = (count==RAS_DEPTH). Both are combinational from registered count.
- Reset deasserted mid-stall: first non-stalled edge advances from RESET_VEC.

Decomposition:
- CtrlDef.v gains NPC_PLUS4/BRANCH/JUMP/JR/RET as 3-bit defines; the existing 2-bit encodings widen in place.
- One sub-module: ras_stack (parameters W, RAS_DEPTH; ports push, pop, push data, top, empty, full, clk, rst_n), holding storage, pointer and count.
- Next-PC mux and PC register stay in next_pc_unit.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> PC=32'h3000 immediately, RasEmpty=1. Release, NPCCtrl=PLUS4 for 3 cycles -> PC 3004, 3008, 300C.
- Branch: PC=3010, NPC=3014, Imm=-2 (32'hFFFF_FFFE), Branch=1 -> PC=300C. Same with Branch=0 -> PC=3014.
- Jump/JR:
  - JUMP with NPC=3014, JumpAddr[25:0]=26'h0000C40 -> PC=32'h0000_3100.
  - JR with JumpAddr=32'h0000_5000 -> PC=5000.
  - Stall=1 with JR -> PC unchanged.
- RAS:
  - 5 Links with NPC=100,200,300,400,500 -> RasFull=1.
  - 4 RETs -> PCs 504, 404, 304, 204.
  - 5th RET with JumpAddr=7000 -> PC=7000, RasEmpty=1.
- Simultaneous RET+Link:
  - Top=304, NPC=600 -> PC=304, top becomes 604, count unchanged.
  - Except concurrent with Stall and Link -> PC=EXC_VEC, RAS count unchanged.
